// File: rtl/mem_seq_pkg.sv
// Shared definitions for the unified memory sequencer.
//   state_e         : sequencer states (fetch, decode wait, data, commit, halt)
//   WORD_W          : bus word width
//   DEFAULT_TIMEOUT : default number of non-ready request cycles before abort
package mem_seq_pkg;

    localparam int WORD_W = 32;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECIDE,
        S_DATA,
        S_COMMIT,
        S_HALT
    } state_e;

endpackage

// File: rtl/unified_mem_sequencer_if.sv
// Unified memory port between the sequencer (master) and memory (slave).
//   mem_req / mem_ready       : request and same-cycle completion
//   mem_addr / mem_wdata      : address and store data, big-endian [0:31]
//   mem_we, mem_byte,
//   mem_half_word,
//   mem_sign_extend           : access attributes
//   mem_rdata                 : read data returned by memory
interface unified_mem_sequencer_if;
    import mem_seq_pkg::*;

    logic              mem_req;
    logic [0:WORD_W-1] mem_addr;
    logic [0:WORD_W-1] mem_wdata;
    logic              mem_we;
    logic              mem_byte;
    logic              mem_half_word;
    logic              mem_sign_extend;
    logic [0:WORD_W-1] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_addr, mem_wdata, mem_we,
               mem_byte, mem_half_word, mem_sign_extend,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_addr, mem_wdata, mem_we,
               mem_byte, mem_half_word, mem_sign_extend,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Wait-state counter for one memory request.
//   clock, reset : system clock, synchronous active-low reset
//   clr          : restart the count (takes priority over inc)
//   inc          : one more cycle of an unanswered request
//   tc           : this cycle is the TIMEOUT-th consecutive unanswered cycle
module mem_wait_timer
    import mem_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc)
            count_d = count_q + 16'd1;
    end

    // Flag the expiring cycle itself so the abort lands on this edge.
    assign tc = inc && (count_q == LAST);

    always_ff @(posedge clock) begin
        if (!reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/unified_mem_sequencer.sv
// Multi-cycle sequencer letting a single-cycle core share one
// variable-latency memory port for instruction fetch and data access.
//   clock, reset           : system clock, synchronous active-low reset
//   iaddr                  : fetch address from the core
//   inst_to_proc           : latched instruction
//   data_req               : decoded instruction needs a load/store
//   addr_from_proc,
//   data_from_proc         : data address and store data
//   *_from_proc attributes : write enable, byte, half word, sign extend
//   data_to_proc           : latched load data
//   stall                  : core must hold all state
//   bus_error              : sticky, set when memory stops responding
//   mem                    : unified memory port (master side)
module unified_mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [0:WORD_W-1] iaddr,
    output logic [0:WORD_W-1] inst_to_proc,
    input  logic              data_req,
    input  logic [0:WORD_W-1] addr_from_proc,
    input  logic [0:WORD_W-1] data_from_proc,
    input  logic              write_enable_from_proc,
    input  logic              byte_from_proc,
    input  logic              half_word_from_proc,
    input  logic              sign_extend_from_proc,
    output logic [0:WORD_W-1] data_to_proc,
    output logic              stall,
    output logic              bus_error,
    unified_mem_sequencer_if.master mem
);

    state_e            state_q, state_d;
    logic [0:WORD_W-1] inst_q, inst_d, data_q, data_d;
    logic [0:WORD_W-1] addr_q, addr_d, wdata_q, wdata_d;
    logic              req_q, req_d, we_q, we_d, byte_q, byte_d;
    logic              half_q, half_d, sext_q, sext_d;
    logic              stall_q, stall_d, bus_error_q, bus_error_d;
    logic              accept, waiting, timeout_hit, state_change;

    // mem_ready only counts while a request is actually on the bus.
    assign accept       = req_q && mem.mem_ready;
    assign waiting      = req_q && !mem.mem_ready;
    assign state_change = (state_d != state_q);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock (clock),
        .reset (reset),
        .clr   (state_change),
        .inc   (waiting),
        .tc    (timeout_hit)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        inst_d      = inst_q;
        data_d      = data_q;
        bus_error_d = bus_error_q;

        case (state_q)
            S_FETCH: if (accept) begin
                inst_d  = mem.mem_rdata;
                state_d = S_DECIDE;
            end
            // One idle cycle lets the core decode inst_to_proc into data_req.
            S_DECIDE: state_d = data_req ? S_DATA : S_COMMIT;
            S_DATA: if (accept) begin
                if (!we_q)
                    data_d = mem.mem_rdata;
                state_d = S_COMMIT;
            end
            S_COMMIT: state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase

        if (timeout_hit) begin
            state_d     = S_HALT;
            bus_error_d = 1'b1;
        end

        // Bus outputs are registered from the next state, so they are
        // all-zero in every cycle without an active request.
        req_d   = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        we_d    = 1'b0;
        byte_d  = 1'b0;
        half_d  = 1'b0;
        sext_d  = 1'b0;
        case (state_d)
            S_FETCH: begin
                req_d  = 1'b1;
                addr_d = iaddr;
            end
            S_DATA: begin
                req_d   = 1'b1;
                addr_d  = addr_from_proc;
                wdata_d = data_from_proc;
                we_d    = write_enable_from_proc;
                byte_d  = byte_from_proc;
                half_d  = half_word_from_proc;
                sext_d  = sign_extend_from_proc;
            end
            default: ;
        endcase
        stall_d = (state_d != S_COMMIT);
    end

    // NOTE: state is updated only here, with non-blocking assignments, so
    // every flop samples the values computed before this edge.
    always_ff @(posedge clock) begin
        // NOTE: reset clears every flop; the first request then goes out
        // in the first cycle after reset is released, and any access in
        // flight is simply dropped.
        if (!reset) begin
            state_q     <= S_FETCH;
            inst_q      <= '0;
            data_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            half_q      <= 1'b0;
            sext_q      <= 1'b0;
            stall_q     <= 1'b1;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_q       <= req_d;
            we_q        <= we_d;
            byte_q      <= byte_d;
            half_q      <= half_d;
            sext_q      <= sext_d;
            stall_q     <= stall_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign inst_to_proc        = inst_q;
    assign data_to_proc        = data_q;
    assign stall               = stall_q;
    assign bus_error           = bus_error_q;
    assign mem.mem_req         = req_q;
    assign mem.mem_addr        = addr_q;
    assign mem.mem_wdata       = wdata_q;
    assign mem.mem_we          = we_q;
    assign mem.mem_byte        = byte_q;
    assign mem.mem_half_word   = half_q;
    assign mem.mem_sign_extend = sext_q;

endmodule

// File: tb/tb_unified_mem_sequencer.sv
// Directed bench for unified_mem_sequencer (TIMEOUT = 4).
// Memory model: read data = address ^ 0x12340000, except address 0x2004
// which returns 0xDEADBEEF; requests to slow_addr wait slow_waits cycles;
// hang forces mem_ready low.
module tb_unified_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] inst_to_proc;
    logic        data_req = 1'b0;
    logic [31:0] addr_from_proc = '0;
    logic [31:0] data_from_proc = '0;
    logic        we_in = 1'b0;
    logic        byte_in = 1'b0;
    logic        half_in = 1'b0;
    logic        sext_in = 1'b0;
    logic [31:0] data_to_proc;
    logic        stall;
    logic        bus_error;

    logic        hang = 1'b0;
    logic [31:0] slow_addr = 32'h2004;
    int          slow_waits = 2;
    int          wcnt = 0;

    int total = 0;
    int bad = 0;

    unified_mem_sequencer_if bus ();

    unified_mem_sequencer #(.TIMEOUT(4)) dut (
        .clock                  (clk),
        .reset                  (reset),
        .iaddr                  (iaddr),
        .inst_to_proc           (inst_to_proc),
        .data_req               (data_req),
        .addr_from_proc         (addr_from_proc),
        .data_from_proc         (data_from_proc),
        .write_enable_from_proc (we_in),
        .byte_from_proc         (byte_in),
        .half_word_from_proc    (half_in),
        .sign_extend_from_proc  (sext_in),
        .data_to_proc           (data_to_proc),
        .stall                  (stall),
        .bus_error              (bus_error),
        .mem                    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_req && !bus.mem_ready)
            wcnt <= wcnt + 1;
        else
            wcnt <= 0;
    end

    assign bus.mem_ready = bus.mem_req && !hang &&
                           (wcnt >= ((bus.mem_addr == slow_addr) ? slow_waits : 0));
    assign bus.mem_rdata = (bus.mem_addr == 32'h2004) ? 32'hDEADBEEF
                                                       : (bus.mem_addr ^ 32'h1234_0000);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction; returns the cycle (1 = fetch) where stall drops.
    task automatic run_instr(output int stall_at, output int reqs, output int we_n,
                             output int byte_n, output int sext_n, output int idle_bad,
                             output logic [31:0] last_addr, output logic [31:0] we_data);
        stall_at = 0; reqs = 0; we_n = 0; byte_n = 0; sext_n = 0; idle_bad = 0;
        last_addr = '0; we_data = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.mem_req) begin
                reqs++;
                last_addr = bus.mem_addr;
                if (bus.mem_we) begin
                    we_n++;
                    we_data = bus.mem_wdata;
                end
                if (bus.mem_byte) byte_n++;
                if (bus.mem_sign_extend) sext_n++;
            end else if (bus.mem_addr != 0 || bus.mem_wdata != 0 || bus.mem_we ||
                         bus.mem_byte || bus.mem_half_word || bus.mem_sign_extend) begin
                idle_bad++;
            end
            if (!stall) begin
                stall_at = i;
                break;
            end
        end
    endtask

    int          s_at, n_req, n_we, n_byte, n_sext, n_idle, n_low, err_at;
    logic [31:0] l_addr, w_data;

    initial begin
        // Reset state.
        repeat (3) tick();
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_bus_error", 32'(bus_error), 32'd0);
        check("rst_inst", inst_to_proc, 32'd0);
        check("rst_data", data_to_proc, 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);

        // Zero-wait ALU instruction.
        iaddr = 32'h100;
        reset = 1'b1;
        run_instr(s_at, n_req, n_we, n_byte, n_sext, n_idle, l_addr, w_data);
        check("alu_stall_at", 32'(s_at), 32'd3);
        check("alu_reqs", 32'(n_req), 32'd1);
        check("alu_addr", l_addr, 32'h100);
        check("alu_idle", 32'(n_idle), 32'd0);
        check("alu_inst", inst_to_proc, 32'h1234_0100);

        // Load with two data-phase wait states: 4 + 2 cycles.
        iaddr = 32'h104; data_req = 1'b1; addr_from_proc = 32'h2004; sext_in = 1'b1;
        run_instr(s_at, n_req, n_we, n_byte, n_sext, n_idle, l_addr, w_data);
        check("load_stall_at", 32'(s_at), 32'd6);
        check("load_reqs", 32'(n_req), 32'd4);
        check("load_addr", l_addr, 32'h2004);
        check("load_sext", 32'(n_sext), 32'd3);
        check("load_we", 32'(n_we), 32'd0);
        check("load_data", data_to_proc, 32'hDEADBEEF);
        check("load_inst", inst_to_proc, 32'h1234_0104);

        // Byte store.
        iaddr = 32'h108; addr_from_proc = 32'h3000; data_from_proc = 32'hAB;
        we_in = 1'b1; byte_in = 1'b1; sext_in = 1'b0;
        run_instr(s_at, n_req, n_we, n_byte, n_sext, n_idle, l_addr, w_data);
        check("st_stall_at", 32'(s_at), 32'd4);
        check("st_we_cycles", 32'(n_we), 32'd1);
        check("st_byte_cycles", 32'(n_byte), 32'd1);
        check("st_wdata", w_data, 32'hAB);
        check("st_addr", l_addr, 32'h3000);
        check("st_idle", 32'(n_idle), 32'd0);
        check("st_data_hold", data_to_proc, 32'hDEADBEEF);

        // Back-to-back zero-wait instructions.
        data_req = 1'b0; we_in = 1'b0; byte_in = 1'b0;
        addr_from_proc = '0; data_from_proc = '0;
        iaddr = 32'h10C;
        run_instr(s_at, n_req, n_we, n_byte, n_sext, n_idle, l_addr, w_data);
        check("b2b_first", 32'(s_at), 32'd3);
        check("b2b_first_inst", inst_to_proc, 32'h1234_010C);
        iaddr = 32'h110;
        run_instr(s_at, n_req, n_we, n_byte, n_sext, n_idle, l_addr, w_data);
        check("b2b_second", 32'(s_at), 32'd3);
        check("b2b_second_addr", l_addr, 32'h110);

        // Reset in the middle of a slow data access.
        iaddr = 32'h114; data_req = 1'b1; addr_from_proc = 32'h2004; sext_in = 1'b1;
        repeat (3) tick();
        check("mid_in_data_req", 32'(bus.mem_req), 32'd1);
        check("mid_in_data_addr", bus.mem_addr, 32'h2004);
        reset = 1'b0;
        tick();
        check("mid_rst_req", 32'(bus.mem_req), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd1);
        check("mid_rst_addr", bus.mem_addr, 32'd0);
        check("mid_rst_sext", 32'(bus.mem_sign_extend), 32'd0);
        check("mid_rst_data", data_to_proc, 32'd0);
        check("mid_rst_inst", inst_to_proc, 32'd0);
        iaddr = 32'h200; data_req = 1'b0; addr_from_proc = '0; sext_in = 1'b0;
        reset = 1'b1;
        run_instr(s_at, n_req, n_we, n_byte, n_sext, n_idle, l_addr, w_data);
        check("mid_refetch_at", 32'(s_at), 32'd3);
        check("mid_refetch_addr", l_addr, 32'h200);

        // Timeout with TIMEOUT = 4 and a silent memory.
        hang = 1'b1; iaddr = 32'h300;
        n_req = 0; n_low = 0; err_at = 0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (bus.mem_req) n_req++;
            if (!stall) n_low++;
            if (bus_error && err_at == 0) err_at = i;
        end
        check("to_req_cycles", 32'(n_req), 32'd4);
        check("to_err_cycle", 32'(err_at), 32'd5);
        check("to_stall_low", 32'(n_low), 32'd0);
        check("to_bus_error", 32'(bus_error), 32'd1);
        check("to_req_final", 32'(bus.mem_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
